// File: rtl/video_stream_capture_pkg.sv
// Shared types and 640x480 timing constants for the grey video capture path.
package video_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        ACTIVE,
        DONE
    } cap_state_t;

    localparam int unsigned H_SYNC  = 96;
    localparam int unsigned H_BACK  = 48;
    localparam int unsigned H_DISP  = 640;
    localparam int unsigned H_FRONT = 16;
    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;

    localparam int unsigned V_SYNC  = 2;
    localparam int unsigned V_BACK  = 33;
    localparam int unsigned V_DISP  = 480;
    localparam int unsigned V_FRONT = 10;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    typedef logic [7:0] pixel_t;

endpackage

// File: rtl/video_stream_capture_if.sv
// Video input stream plus frame-buffer write port seen by the capture block.
interface video_stream_capture_if #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 8
);

    logic              vin_vsync;
    logic              vin_hsync;
    logic              vin_valid;
    logic [DATA_W-1:0] vin_dat;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_dat;

    // Stream source / buffer side
    modport master (
        output vin_vsync, vin_hsync, vin_valid, vin_dat,
        input  wr_en, wr_addr, wr_dat
    );

    // Capture side
    modport slave (
        input  vin_vsync, vin_hsync, vin_valid, vin_dat,
        output wr_en, wr_addr, wr_dat
    );

endinterface

// File: rtl/video_stream_capture_line_counter.sv
// Column/line bookkeeping for frame capture; CAP_BOTTOM_UP_EN selects BMP row order.
module video_line_counter
    import video_pkg::*;
#(
    parameter int unsigned MAX_XRES = 640,
    parameter int unsigned MAX_YRES = 480,
    parameter int unsigned ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              accept_i,
    input  logic              line_end_i,
    output logic [15:0]       col_o,
    output logic [15:0]       line_o,
    output logic [ADDR_W-1:0] line_base_o,
    output logic [15:0]       xres_o,
    output logic              col_full_o,
    output logic              line_open_o,
    output logic              first_line_o,
    output logic              len_mismatch_o,
    output logic              frame_full_o
);

    localparam logic [15:0]       XMAX   = 16'(MAX_XRES);
    localparam logic [15:0]       YLAST  = 16'(MAX_YRES - 1);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(MAX_XRES);
`ifdef CAP_BOTTOM_UP_EN
    localparam logic [ADDR_W-1:0] BASE_INIT = ADDR_W'((MAX_YRES - 1) * MAX_XRES);
`else
    localparam logic [ADDR_W-1:0] BASE_INIT = '0;
`endif

    logic [15:0]       col_q,  col_d;
    logic [15:0]       line_q, line_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [15:0]       xres_q, xres_d;

    assign col_o          = col_q;
    assign line_o         = line_q;
    assign line_base_o    = base_q;
    assign xres_o         = xres_q;
    assign col_full_o     = (col_q >= XMAX);
    assign line_open_o    = (col_q != '0);
    assign first_line_o   = (line_q == '0);
    assign len_mismatch_o = line_end_i & ~first_line_o & (col_q != xres_q);
    assign frame_full_o   = line_end_i & (line_q == YLAST);

    always_comb begin
        col_d  = col_q;
        line_d = line_q;
        base_d = base_q;
        xres_d = xres_q;
        if (clear_i) begin
            col_d  = '0;
            line_d = '0;
            base_d = BASE_INIT;
            xres_d = '0;
        end else if (line_end_i) begin
            if (first_line_o) begin
                xres_d = col_q;
            end
            col_d  = '0;
            line_d = line_q + 16'd1;
`ifdef CAP_BOTTOM_UP_EN
            base_d = base_q - STRIDE;
`else
            base_d = base_q + STRIDE;
`endif
        end else if (accept_i) begin
            col_d = col_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q  <= '0;
            line_q <= '0;
            base_q <= BASE_INIT;
            xres_q <= '0;
        end else begin
            col_q  <= col_d;
            line_q <= line_d;
            base_q <= base_d;
            xres_q <= xres_d;
        end
    end

endmodule

// File: rtl/video_stream_capture.sv
// One-frame grey video capture into a linear frame buffer with resolution check.
// Define CAP_BOTTOM_UP_EN to write rows in BMP (bottom-up) order.
module video_stream_capture
    import video_pkg::*;
#(
    parameter int unsigned MAX_XRES = 640,
    parameter int unsigned MAX_YRES = 480,
    parameter int unsigned ADDR_W   = 19,
    parameter int unsigned DATA_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    video_stream_capture_if.slave vif,
    input  logic                 cap_begin,
    output logic                 cap_busy,
    output logic                 cap_done,
    output logic                 cap_err,
    output logic [15:0]          cap_xres,
    output logic [15:0]          cap_yres
);

    cap_state_t        state_q;
    logic              begin_q, vsync_q, valid_q;
    logic              end_pend_q;
    logic              busy_q, done_q, err_q;
    logic [15:0]       yres_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_dat_q;

    logic              begin_rise, vsync_rise, valid_fall;
    logic              in_active, accept, drop, line_end, arm;
    logic [15:0]       lc_col, lc_line, lc_xres;
    logic [ADDR_W-1:0] lc_base;
    logic              lc_col_full, lc_line_open, lc_first_line;
    logic              lc_len_mismatch, lc_frame_full;
    logic              unused_hsync;

    assign unused_hsync = vif.vin_hsync;

    always_comb begin
        begin_rise = cap_begin & ~begin_q;
        vsync_rise = vif.vin_vsync & ~vsync_q;
        valid_fall = ~vif.vin_valid & valid_q;
        in_active  = (state_q == ACTIVE);
        arm        = (state_q == IDLE) & begin_rise;
        accept     = in_active & ~end_pend_q & vif.vin_valid & ~lc_col_full;
        drop       = in_active & ~end_pend_q & vif.vin_valid & lc_col_full;
        // A fall with no accepted pixel is leftover from before the frame began
        line_end   = in_active & valid_fall & lc_line_open;
    end

    video_line_counter #(
        .MAX_XRES(MAX_XRES),
        .MAX_YRES(MAX_YRES),
        .ADDR_W  (ADDR_W)
    ) u_line_counter (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (arm),
        .accept_i      (accept),
        .line_end_i    (line_end),
        .col_o         (lc_col),
        .line_o        (lc_line),
        .line_base_o   (lc_base),
        .xres_o        (lc_xres),
        .col_full_o    (lc_col_full),
        .line_open_o   (lc_line_open),
        .first_line_o  (lc_first_line),
        .len_mismatch_o(lc_len_mismatch),
        .frame_full_o  (lc_frame_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            begin_q    <= 1'b0;
            vsync_q    <= 1'b0;
            valid_q    <= 1'b0;
            end_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            yres_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_dat_q   <= '0;
        end else begin
            begin_q <= cap_begin;
            vsync_q <= vif.vin_vsync;
            valid_q <= vif.vin_valid;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (begin_rise) begin
                        state_q    <= ARMED;
                        busy_q     <= 1'b1;
                        err_q      <= 1'b0;
                        yres_q     <= '0;
                        end_pend_q <= 1'b0;
                    end
                end
                ARMED: begin
                    if (vsync_rise) begin
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (accept) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= lc_base + ADDR_W'(lc_col);
                        wr_dat_q  <= vif.vin_dat;
                    end
                    if (drop || lc_len_mismatch) begin
                        err_q <= 1'b1;
                    end
                    // An end coinciding with an accepted pixel waits one cycle so
                    // the write strobe always leads cap_done.
                    if (end_pend_q || ((lc_frame_full || vsync_rise) && !accept)) begin
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        end_pend_q <= 1'b0;
                        yres_q     <= lc_line + {15'd0, line_end};
                    end else if (vsync_rise) begin
                        end_pend_q <= 1'b1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cap_busy    = busy_q;
    assign cap_done    = done_q;
    assign cap_err     = err_q;
    assign cap_xres    = lc_xres;
    assign cap_yres    = yres_q;
    assign vif.wr_en   = wr_en_q;
    assign vif.wr_addr = wr_addr_q;
    assign vif.wr_dat  = wr_dat_q;

endmodule

// File: tb/tb_video_stream_capture.sv
// Randomized frame-capture bench with a per-frame reference model and write scoreboard.
module tb_video_stream_capture;

    localparam int unsigned MAX_X = 8;
    localparam int unsigned MAX_Y = 4;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 8;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cap_begin;
    logic        cap_busy, cap_done, cap_err;
    logic [15:0] cap_xres, cap_yres;

    video_stream_capture_if #(.ADDR_W(AW), .DATA_W(DW)) vif ();

    video_stream_capture #(
        .MAX_XRES(MAX_X),
        .MAX_YRES(MAX_Y),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .vif      (vif),
        .cap_begin(cap_begin),
        .cap_busy (cap_busy),
        .cap_done (cap_done),
        .cap_err  (cap_err),
        .cap_xres (cap_xres),
        .cap_yres (cap_yres)
    );

    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Scoreboard: every write strobe must match the next expected (addr, data)
    wr_t exp_q[$];
    wr_t mon_e;
    int  cyc         = 0;
    int  last_wr_cyc = -1;
    int  done_cyc    = -1;
    int  done_cnt    = 0;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (vif.wr_en === 1'b1) begin
            check_eq("wr_expected", longint'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check_eq("wr_addr", vif.wr_addr, mon_e.a);
                check_eq("wr_dat", vif.wr_dat, mon_e.d);
            end
            last_wr_cyc = cyc;
        end
        if (cap_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    logic [7:0] pix_a [MAX_Y][16];
    int         len_a [MAX_Y];

    function automatic int row_base(input int l);
`ifdef CAP_BOTTOM_UP_EN
        return (int'(MAX_Y) - 1 - l) * int'(MAX_X);
`else
        return l * int'(MAX_X);
`endif
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_pixels(input int l, input int n);
        for (int c = 0; c < n; c++) begin
            vif.vin_valid = 1'b1;
            vif.vin_dat   = pix_a[l][c];
            tick();
        end
        vif.vin_valid = 1'b0;
    endtask

    // nl lines; early=1 ends the frame with a vsync rise; abort_line>=0 resets mid-line
    task automatic run_frame(input int nl, input bit early, input int abort_line);
        int  n;
        int  xres_e;
        int  yres_e;
        bit  err_e;
        wr_t w;

        exp_q.delete();
        xres_e = 0;
        err_e  = 1'b0;
        for (int l = 0; l < nl; l++) begin
            n = (len_a[l] > int'(MAX_X)) ? int'(MAX_X) : len_a[l];
            if (len_a[l] > int'(MAX_X)) err_e = 1'b1;
            if (l == 0) xres_e = n;
            else if (n != xres_e) err_e = 1'b1;
            for (int c = 0; c < n; c++) begin
                w.a = AW'(row_base(l) + c);
                w.d = pix_a[l][c];
                exp_q.push_back(w);
            end
        end
        yres_e = nl;

        done_cnt    = 0;
        done_cyc    = -1;
        last_wr_cyc = -1;

        cap_begin = 1'b1;
        tick();
        cap_begin = 1'b0;
        check_eq("busy_armed", cap_busy, 1);
        // Pixels before and at the vsync rise must be ignored
        vif.vin_valid = 1'b1;
        vif.vin_dat   = 8'($urandom);
        tick();
        vif.vin_vsync = 1'b1;
        vif.vin_dat   = 8'($urandom);
        tick();
        vif.vin_valid = 1'b0;
        tick();
        vif.vin_vsync = 1'b0;
        tick(2);

        for (int l = 0; l < nl; l++) begin
            if (l == abort_line) begin
                drive_pixels(l, (len_a[l] + 1) / 2);
                rst = 1'b1;
                tick();
                check_eq("abort_wr_en", vif.wr_en, 0);
                check_eq("abort_busy", cap_busy, 0);
                check_eq("abort_done", cap_done, 0);
                rst = 1'b0;
                exp_q.delete();
                tick(6);
                check_eq("abort_no_done", done_cnt, 0);
                return;
            end
            drive_pixels(l, len_a[l]);
            vif.vin_hsync = 1'b1;
            tick();
            vif.vin_hsync = 1'b0;
            if (l + 1 < nl) cap_begin = 1'b1;
            tick();
            cap_begin = 1'b0;
            tick($urandom_range(0, 2));
        end

        if (early) begin
            vif.vin_vsync = 1'b1;
            tick();
        end
        for (int i = 0; i < 40 && done_cnt == 0; i++) tick();
        tick(3);
        vif.vin_vsync = 1'b0;

        check_eq("done_pulses", done_cnt, 1);
        check_eq("xres", cap_xres, xres_e);
        check_eq("yres", cap_yres, yres_e);
        check_eq("err", cap_err, err_e);
        check_eq("busy_after", cap_busy, 0);
        check_eq("writes_left", exp_q.size(), 0);
        if (last_wr_cyc >= 0) begin
            check_eq("done_after_wr", longint'(done_cyc > last_wr_cyc), 1);
            if (!early) check_eq("done_latency", done_cyc - last_wr_cyc, 1);
        end
        tick(2);
    endtask

    task automatic fill_ramp();
        for (int l = 0; l < int'(MAX_Y); l++) begin
            len_a[l] = int'(MAX_X);
            for (int c = 0; c < 16; c++) pix_a[l][c] = 8'(16 * l + c);
        end
    endtask

    task automatic fill_random();
        for (int l = 0; l < int'(MAX_Y); l++) begin
            len_a[l] = ($urandom_range(0, 9) < 6) ? int'(MAX_X) : int'($urandom_range(1, 10));
            for (int c = 0; c < 16; c++) pix_a[l][c] = 8'($urandom);
        end
    endtask

    initial begin
        int nl;
        rst           = 1'b1;
        cap_begin     = 1'b0;
        vif.vin_vsync = 1'b0;
        vif.vin_hsync = 1'b0;
        vif.vin_valid = 1'b0;
        vif.vin_dat   = '0;
        tick(3);
        check_eq("rst_wr_en", vif.wr_en, 0);
        check_eq("rst_busy", cap_busy, 0);
        check_eq("rst_done", cap_done, 0);
        check_eq("rst_err", cap_err, 0);
        check_eq("rst_xres", cap_xres, 0);
        check_eq("rst_yres", cap_yres, 0);
        rst = 1'b0;
        tick(2);

        fill_ramp();
        run_frame(4, 1'b0, -1);

        fill_ramp();
        len_a[2] = 6;
        run_frame(4, 1'b0, -1);

        fill_random();
        len_a[0] = 10;
        run_frame(1, 1'b1, -1);

        fill_random();
        for (int l = 0; l < int'(MAX_Y); l++) len_a[l] = int'(MAX_X);
        run_frame(2, 1'b1, -1);

        fill_random();
        for (int l = 0; l < int'(MAX_Y); l++) len_a[l] = int'(MAX_X);
        run_frame(4, 1'b0, 1);
        run_frame(4, 1'b0, -1);

        run_frame(0, 1'b1, -1);

        for (int f = 0; f < 8; f++) begin
            fill_random();
            nl = int'($urandom_range(1, MAX_Y));
            run_frame(nl, nl < int'(MAX_Y), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
